// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide engine.
package muldiv_unit_pkg;

  localparam int MD_ITERS = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  // Ops that occupy the engine for the full iterative sequence.
  function automatic logic is_long_op(muldiv_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_div_op(muldiv_op_t op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_signed_op(muldiv_op_t op);
    return op inside {MD_MULT, MD_DIV};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Pipeline-side handshake and HI/LO read bus of the multiply/divide engine.
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
);

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, abort,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, abort,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_md_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a
// 2*WIDTH accumulator holding {upper, lower} halves.
module muldiv_unit_md_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] part_rem;
  logic [WIDTH:0] diff;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: acc = {remainder, remaining dividend bits / quotient bits}.
    part_rem = acc[2*WIDTH-1:WIDTH-1];
    diff     = part_rem - {1'b0, operand};

    if (is_div) begin
      if (diff[WIDTH]) acc_next = {acc[2*WIDTH-2:0], 1'b0};
      else             acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers,
// with immediate MTHI/MTLO writes and an abort for pipeline flush.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int               CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  muldiv_state_t      state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_next, prod_fixed;
  logic [WIDTH-1:0]   operand, hi_q, lo_q, mag_a, mag_b, fix_hi, fix_lo;
  logic               is_div_q, res_neg_q, rem_neg_q, done_q;
  logic               busy, idle_req, load_en, step_en, mthi_en, mtlo_en, fix_en;
  logic               sign_a, sign_b, op_div;

  muldiv_unit_md_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start && is_long_op(bus.op)) state_next = RUN;
        RUN:     if (cnt == LAST_STEP)                state_next = FIX;
        FIX:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    idle_req = (state == IDLE) && bus.start && !bus.abort;
    load_en  = idle_req && is_long_op(bus.op);
    mthi_en  = idle_req && (bus.op == MD_MTHI);
    mtlo_en  = idle_req && (bus.op == MD_MTLO);
    step_en  = (state == RUN);
    // Abort wins over the final write so a flushed op never touches HI/LO.
    fix_en   = (state == FIX) && !bus.abort;
  end

  always_comb begin
    op_div = is_div_op(bus.op);
    sign_a = is_signed_op(bus.op) && bus.src_a[WIDTH-1];
    sign_b = is_signed_op(bus.op) && bus.src_b[WIDTH-1];
    mag_a  = sign_a ? -bus.src_a : bus.src_a;
    mag_b  = sign_b ? -bus.src_b : bus.src_b;
  end

  always_comb begin
    prod_fixed = res_neg_q ? -acc : acc;
    if (is_div_q) begin
      fix_lo = res_neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo = prod_fixed[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      operand   <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= fix_en;

      if (load_en) begin
        cnt      <= '0;
        is_div_q <= op_div;
        // A zero divisor yields the raw all-ones quotient, so its sign fix is suppressed.
        res_neg_q <= (sign_a ^ sign_b) && !(op_div && (bus.src_b == '0));
        rem_neg_q <= sign_a;
        if (op_div) begin
          acc     <= {{WIDTH{1'b0}}, mag_a};
          operand <= mag_b;
        end else begin
          acc     <= {{WIDTH{1'b0}}, mag_b};
          operand <= mag_a;
        end
      end else if (step_en) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
      end

      if (mthi_en) hi_q <= bus.src_a;
      if (mtlo_en) lo_q <= bus.src_a;
      if (fix_en) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: directed corner cases plus randomized traffic against
// an arithmetic/latency reference model compared every cycle.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Reference model: pending result plus remaining busy cycles.
  int             m_rem;
  logic [W-1:0]   m_hi, m_lo;
  logic           m_done;
  logic [2*W-1:0] m_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              q, r;
    case (op)
      MD_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      MD_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        return 64'(up);
      end
      MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic model_clear();
    m_rem  = 0;
    m_hi   = '0;
    m_lo   = '0;
    m_done = 1'b0;
    m_pend = '0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else begin
      m_done = 1'b0;
      if (bus.abort) begin
        m_rem = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        case (bus.op)
          MD_MTHI: m_hi = bus.src_a;
          MD_MTLO: m_lo = bus.src_a;
          default: begin
            m_pend = ref_op(bus.op, bus.src_a, bus.src_b);
            m_rem  = LAT;
          end
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", 64'(bus.busy), 64'(m_rem > 0));
      check("cyc_done", 64'(bus.done), 64'(m_done));
      check("cyc_hi",   64'(bus.hi),   64'(m_hi));
      check("cyc_lo",   64'(bus.lo),   64'(m_lo));
    end
  end

  task automatic wait_done(input string name, output int busy_cnt);
    bit got = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1'b1;
      else          tick();
    end
    check({name, "_done_seen"}, 64'(got), 64'h1);
  endtask

  task automatic do_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_cnt;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
    wait_done(name, busy_cnt);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    check({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(15));
      4:       return -32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = MD_MULT;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.abort = 1'b0;
    model_clear();
    cmp_en = 1'b1;

    check("ref_multu", ref_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    check("ref_div",   ref_op(MD_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

    #1;
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_hi",   64'(bus.hi),   64'h0);
    check("rst_lo",   64'(bus.lo),   64'h0);
    tick();
    tick();
    reset = 1'b0;

    do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_100_7", MD_DIVU, 32'd100,       32'd7,         32'd2,         32'd14);
    do_op("divu_by0",  MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
    do_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);

    // Back-to-back MTHI/MTLO.
    bus.start = 1'b1; bus.op = MD_MTHI; bus.src_a = 32'h1234_5678;
    tick();
    check("mthi_hi",   64'(bus.hi),   64'h1234_5678);
    check("mthi_busy", 64'(bus.busy), 64'h0);
    bus.op = MD_MTLO; bus.src_a = 32'h9ABC_DEF0;
    tick();
    bus.start = 1'b0;
    check("mtlo_lo",   64'(bus.lo),   64'h9ABC_DEF0);
    check("mtlo_done", 64'(bus.done), 64'h0);
    tick();
    check("mtlo_done2", 64'(bus.done), 64'h0);

    // Start held while busy must be ignored.
    bus.start = 1'b1; bus.op = MD_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd5;
    tick();
    bus.op = MD_DIVU; bus.src_a = 32'd1; bus.src_b = 32'd1;
    repeat (5) tick();
    bus.start = 1'b0;
    wait_done("ign_start", bc);
    check("ign_start_hi", 64'(bus.hi), 64'h0);
    check("ign_start_lo", 64'(bus.lo), 64'd15);

    // Abort in RUN cycle 10.
    bus.start = 1'b1; bus.op = MD_MULT; bus.src_a = 32'h0001_1111; bus.src_b = 32'h0000_0222;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_run_busy", 64'(bus.busy), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_run_done", 64'(bus.done), 64'h0);
    end
    check("abort_run_hi", 64'(bus.hi), 64'h0);
    check("abort_run_lo", 64'(bus.lo), 64'd15);

    // Abort in the FIX cycle.
    bus.start = 1'b1; bus.op = MD_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (W) tick();
    check("fix_still_busy", 64'(bus.busy), 64'h1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_fix_busy", 64'(bus.busy), 64'h0);
    check("abort_fix_done", 64'(bus.done), 64'h0);
    check("abort_fix_hi",   64'(bus.hi),   64'h0);
    check("abort_fix_lo",   64'(bus.lo),   64'd15);

    // Abort together with MTHI in IDLE drops the write.
    bus.start = 1'b1; bus.op = MD_MTHI; bus.src_a = 32'h0000_ABCD; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_mthi_hi", 64'(bus.hi), 64'h0);

    // Reset mid-RUN clears HI/LO asynchronously.
    bus.start = 1'b1; bus.op = MD_MULTU; bus.src_a = 32'hFFFF_FFFF; bus.src_b = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_mid_hi",   64'(bus.hi),   64'h0);
    check("rst_mid_lo",   64'(bus.lo),   64'h0);
    check("rst_mid_busy", 64'(bus.busy), 64'h0);
    tick();
    tick();
    reset = 1'b0;

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom_range(3) == 0);
      bus.op    = muldiv_op_t'(3'($urandom_range(5)));
      bus.src_a = pick();
      bus.src_b = pick();
      bus.abort = ($urandom_range(63) == 0);
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (LAT + 4) tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
